// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port VRAM between VGA scanout prefetch
// and a CPU req/ack port. A grant is decided each cycle and issued on oMem*
// the next cycle; read data returns one cycle after the address.
// Optional build macro: VGA_ARB_FAIRNESS_EN (bounds CPU starvation while VGA
// is urgent).
module vga_vram_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 3,
    parameter int FRAME_WORDS = 256,
    parameter int FIFO_DEPTH  = 4,
    parameter int URGENT_LVL  = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iPixelEn,
    input  logic              iVisible,
    input  logic              iFrameStart,
    input  logic              iClrUnderrun,
    input  logic              iCpuReq,
    input  logic              iCpuWE,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuWData,
    output logic              oCpuAck,
    output logic [DATA_W-1:0] oCpuRData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWE,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [DATA_W-1:0] oPixel,
    output logic              oUnderrun
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 2;
    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, G_VGA, G_CPU_RD, G_CPU_WR} state_t;

    // state holds the grant currently on oMem*; next_state is this cycle's decision
    state_t state, next_state;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              fetch_en;
    logic              vga_d1;      // VGA read whose data is on iMemRData now
    logic              cpu_ack_rd;  // ack cycle belongs to a read
    logic [LVL_W-1:0]  level;
    logic              cpu_busy, vga_ok, fifo_empty, push, pop, fair_force;
    state_t            cpu_state;

    // level counts words already buffered plus VGA reads still on their way
    assign level      = LVL_W'(fifo_cnt) + LVL_W'(state == G_VGA) + LVL_W'(vga_d1);
    // a CPU op blocks new CPU grants through its ack cycle
    assign cpu_busy   = (state == G_CPU_RD) || (state == G_CPU_WR) || oCpuAck;
    // no fetch is decided on a frame-start cycle: it would use the stale address
    assign vga_ok     = fetch_en && !iFrameStart;
    assign fifo_empty = (fifo_cnt == '0);
    // a restart drops data arriving in the same cycle along with the flush
    assign push       = vga_d1 && !iFrameStart;
    assign pop        = iPixelEn && iVisible && !fifo_empty;
    assign cpu_state  = iCpuWE ? G_CPU_WR : G_CPU_RD;
    assign oCpuRData  = cpu_ack_rd ? iMemRData : '0;

`ifdef VGA_ARB_FAIRNESS_EN
    logic [2:0] fair_cnt;
    assign fair_force = (fair_cnt == 3'd7) && !fifo_empty;

    // count consecutive VGA grants that happen while the CPU is waiting
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            fair_cnt <= '0;
        else if (!iCpuReq || next_state == G_CPU_RD || next_state == G_CPU_WR)
            fair_cnt <= '0;
        else if (next_state == G_VGA && fair_cnt != 3'd7)
            fair_cnt <= fair_cnt + 3'd1;
    end
`else
    assign fair_force = 1'b0;
`endif

    // grant state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // grant decision: urgent VGA, then CPU, then opportunistic VGA prefetch
    always_comb begin
        next_state = IDLE;
        if (fair_force && iCpuReq && !cpu_busy)
            next_state = cpu_state;
        else if (vga_ok && level < LVL_W'(URGENT_LVL))
            next_state = G_VGA;
        else if (iCpuReq && !cpu_busy)
            next_state = cpu_state;
        else if (vga_ok && level < LVL_W'(FIFO_DEPTH))
            next_state = G_VGA;
    end

    // register the decided access onto the VRAM port
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oMemAddr  <= '0;
            oMemWE    <= 1'b0;
            oMemWData <= '0;
        end else begin
            oMemAddr  <= '0;
            oMemWE    <= 1'b0;
            oMemWData <= '0;
            case (next_state)
                G_VGA:    oMemAddr <= fetch_addr;
                G_CPU_RD: oMemAddr <= iCpuAddr;
                G_CPU_WR: begin
                    oMemAddr  <= iCpuAddr;
                    oMemWE    <= 1'b1;
                    oMemWData <= iCpuWData;
                end
                default: ;
            endcase
        end
    end

    // fetch address / frame word counter; disarms after the last word is issued
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fetch_addr <= '0;
            fetch_cnt  <= '0;
            fetch_en   <= 1'b0;
        end else if (iFrameStart) begin
            fetch_addr <= '0;
            fetch_cnt  <= '0;
            fetch_en   <= 1'b1;
        end else if (next_state == G_VGA) begin
            fetch_addr <= fetch_addr + 1'b1;
            fetch_cnt  <= fetch_cnt + 1'b1;
            if (fetch_cnt == CNT_W'(FRAME_WORDS - 1))
                fetch_en <= 1'b0;
        end
    end

    // return-path tracking; a frame start kills the VGA read on the bus
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vga_d1     <= 1'b0;
            oCpuAck    <= 1'b0;
            cpu_ack_rd <= 1'b0;
        end else begin
            vga_d1     <= (state == G_VGA) && !iFrameStart;
            oCpuAck    <= (state == G_CPU_RD) || (state == G_CPU_WR);
            cpu_ack_rd <= (state == G_CPU_RD);
        end
    end

    // prefetch FIFO storage
    always_ff @(posedge Clock) begin
        if (push) fifo_mem[wr_ptr] <= iMemRData;
    end

    // FIFO pointers and occupancy; frame start flushes
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (iFrameStart) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // pixel output and sticky underrun (set beats clear)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oPixel    <= '0;
            oUnderrun <= 1'b0;
        end else begin
            if (iPixelEn)
                oPixel <= pop ? fifo_mem[rd_ptr] : '0;
            if (iPixelEn && iVisible && fifo_empty)
                oUnderrun <= 1'b1;
            else if (iClrUnderrun)
                oUnderrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: table-driven pop/underrun vectors,
// then hand sequences for scanout, CPU timing, restart and reset.
module tb_vga_vram_arbiter;
    logic       Clock, Reset;
    logic       iPixelEn, iVisible, iFrameStart, iClrUnderrun;
    logic       iCpuReq, iCpuWE;
    logic [7:0] iCpuAddr;
    logic [2:0] iCpuWData;
    logic       oCpuAck;
    logic [2:0] oCpuRData;
    logic [7:0] oMemAddr;
    logic       oMemWE;
    logic [2:0] oMemWData;
    logic [2:0] iMemRData;
    logic [2:0] oPixel;
    logic       oUnderrun;

    int checks = 0;
    int failures = 0;

    vga_vram_arbiter dut (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn), .iVisible(iVisible),
        .iFrameStart(iFrameStart), .iClrUnderrun(iClrUnderrun),
        .iCpuReq(iCpuReq), .iCpuWE(iCpuWE), .iCpuAddr(iCpuAddr),
        .iCpuWData(iCpuWData), .oCpuAck(oCpuAck), .oCpuRData(oCpuRData),
        .oMemAddr(oMemAddr), .oMemWE(oMemWE), .oMemWData(oMemWData),
        .iMemRData(iMemRData), .oPixel(oPixel), .oUnderrun(oUnderrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // VRAM model: preloaded with addr[2:0] while reset is held, 1-cycle read
    logic [2:0] vram [256];
    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) vram[i] <= 3'(i);
        end else if (oMemWE) begin
            vram[oMemAddr] <= oMemWData;
        end
        iMemRData <= vram[oMemAddr];
    end

    typedef struct {
        logic pe, vis, clr;
        logic [2:0] exp_pix;
        logic exp_und;
    } vec_t;
    vec_t vecs [9];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0};

        Reset = 1'b1; iPixelEn = 0; iVisible = 0; iFrameStart = 0; iClrUnderrun = 0;
        iCpuReq = 0; iCpuWE = 0; iCpuAddr = '0; iCpuWData = '0;
        repeat (3) step();
        chk("rst_ack", oCpuAck, 0);
        chk("rst_memaddr", oMemAddr, 0);
        chk("rst_memwe", oMemWE, 0);
        chk("rst_pixel", oPixel, 0);
        chk("rst_underrun", oUnderrun, 0);
        Reset = 1'b0;
        step();
        chk("post_rst_memaddr", oMemAddr, 0);

        // fetch disabled (no frame start yet): FIFO is empty for every vector
        for (int v = 0; v < 9; v++) begin
            iPixelEn = vecs[v].pe; iVisible = vecs[v].vis; iClrUnderrun = vecs[v].clr;
            step();
            chk($sformatf("vec%0d_pixel", v), oPixel, vecs[v].exp_pix);
            chk($sformatf("vec%0d_underrun", v), oUnderrun, vecs[v].exp_und);
        end
        iPixelEn = 0; iVisible = 0; iClrUnderrun = 0;

        // scanout of one frame, pixel every 2nd cycle
        iFrameStart = 1; step(); iFrameStart = 0;
        repeat (8) step();
        iVisible = 1;
        for (int k = 0; k < 256; k++) begin
            iPixelEn = 1; step();
            chk($sformatf("scan_pix%0d", k), oPixel, k % 8);
            iPixelEn = 0; step();
        end
        chk("scan_underrun", oUnderrun, 0);

        // refill FIFO (no pixels), then CPU write with FIFO full
        iFrameStart = 1; step(); iFrameStart = 0;
        repeat (10) step();
        iCpuReq = 1; iCpuWE = 1; iCpuAddr = 8'h05; iCpuWData = 3'b110;
        step();
        chk("wr_addr", oMemAddr, 8'h05);
        chk("wr_we", oMemWE, 1);
        chk("wr_data", oMemWData, 3'b110);
        chk("wr_ack_early", oCpuAck, 0);
        step();
        chk("wr_ack", oCpuAck, 1);
        iCpuReq = 0; iCpuWE = 0;
        step();
        chk("wr_ack_clear", oCpuAck, 0);
        iCpuReq = 1; iCpuAddr = 8'h05;
        step();
        chk("rd_addr", oMemAddr, 8'h05);
        chk("rd_we", oMemWE, 0);
        step();
        chk("rd_ack", oCpuAck, 1);
        chk("rd_data", oCpuRData, 3'b110);
        iCpuReq = 0;
        step();

        // back-to-back reads with FIFO full: one grant every 3rd cycle, no VGA slots
        iCpuReq = 1; iCpuWE = 0;
        for (int i = 0; i < 4; i++) begin
            iCpuAddr = 8'h80 + 8'(i);
            if (i > 0) begin
                step();
                chk("b2b_idle_addr", oMemAddr, 0);
                chk("b2b_idle_ack", oCpuAck, 0);
            end
            step();
            chk($sformatf("b2b_addr%0d", i), oMemAddr, 8'h80 + i);
            chk("b2b_noack", oCpuAck, 0);
            step();
            chk($sformatf("b2b_ack%0d", i), oCpuAck, 1);
            chk($sformatf("b2b_data%0d", i), oCpuRData, i);
            chk("b2b_ackcyc_addr", oMemAddr, 0);
        end
        iCpuReq = 0;
        step();

        // restart with a VGA read and a CPU read in flight
        iPixelEn = 1; iVisible = 1; iCpuReq = 1; iCpuWE = 0; iCpuAddr = 8'h85;
        step();
        iPixelEn = 0;
        chk("fs_pop_pixel", oPixel, 0);
        chk("fs_cpu_addr", oMemAddr, 8'h85);
        step();
        chk("fs_vga_addr", oMemAddr, 8'h04);
        chk("fs_cpu_ack", oCpuAck, 1);
        chk("fs_cpu_data", oCpuRData, 3'd5);
        iFrameStart = 1; iCpuReq = 0;
        step();
        iFrameStart = 0;
        chk("fs_ack_clear", oCpuAck, 0);
        repeat (10) step();
        for (int k = 0; k < 3; k++) begin
            iPixelEn = 1; step();
            chk($sformatf("fs_pix%0d", k), oPixel, k);
            iPixelEn = 0; step();
        end
        chk("fs_underrun", oUnderrun, 0);

        // reset mid CPU write: drops op, no ack
        iCpuReq = 1; iCpuWE = 1; iCpuAddr = 8'h10; iCpuWData = 3'd7;
        step();
        chk("mr_we_before", oMemWE, 1);
        Reset = 1; iCpuReq = 0; iCpuWE = 0;
        #1;
        chk("mr_we_async", oMemWE, 0);
        chk("mr_addr_async", oMemAddr, 0);
        step();
        Reset = 0;
        step();
        chk("mr_no_ack", oCpuAck, 0);
        step();
        chk("mr_no_ack2", oCpuAck, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
